// File: rtl/cfg_cmd_pkg.sv
// cfg_cmd_pkg: shared constants and helpers for the UART config
// command parser (error codes, ASCII, FSM encoding).
package cfg_cmd_pkg;

  localparam logic [2:0] ERR_OK  = 3'b000;
  localparam logic [2:0] ERR_FMT = 3'b010;
  localparam logic [2:0] ERR_RNG = 3'b011;
  localparam logic [2:0] ERR_CNT = 3'b100;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_X     = 8'h78;
  localparam logic [7:0] CH_R     = 8'h72;

  localparam logic [2:0] ST_COLLECT  = 3'd0;
  localparam logic [2:0] ST_SCAN_KEY = 3'd1;
  localparam logic [2:0] ST_SCAN_A   = 3'd2;
  localparam logic [2:0] ST_SCAN_B   = 3'd3;
  localparam logic [2:0] ST_CHECK    = 3'd4;
  localparam logic [2:0] ST_RESULT   = 3'd5;

  function automatic logic [7:0] to_lower(
    input logic [7:0] c
  );
    return (c >= 8'h41 && c <= 8'h5A) ?
      (c | 8'h20) : c;
  endfunction

  function automatic logic is_digit(
    input logic [7:0] c
  );
    return (c >= CH_0) && (c <= 8'h39);
  endfunction

  // Expected keyword char at pos>0; pos 0 picks x/range.
  function automatic logic [7:0] key_char(
    input logic       is_x,
    input logic [2:0] pos
  );
    logic [7:0] k;
    k = 8'hFF;
    if (is_x) begin
      if (pos == 3'd1) k = CH_EQ;
    end else begin
      case (pos)
        3'd1:    k = 8'h61;
        3'd2:    k = 8'h6E;
        3'd3:    k = 8'h67;
        3'd4:    k = 8'h65;
        3'd5:    k = CH_EQ;
        default: k = 8'hFF;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/dec_field_acc.sv
// dec_field_acc: signed 1-2 digit decimal accumulator shared by
// every numeric field of a command.
module dec_field_acc
  import cfg_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              stb,
  input  logic              neg,
  input  logic [7:0]        ch,
  output logic signed [7:0] value,
  output logic              empty,
  output logic              has_neg,
  output logic              ovl,
  output logic              nondig
);

  logic [7:0] acc_q;
  logic [1:0] cnt_q;
  logic       neg_q;
  logic       dig;

  assign dig     = is_digit(ch);
  assign ovl     = stb & dig & (cnt_q == 2'd2);
  assign nondig  = stb & ~dig;
  assign empty   = (cnt_q == 2'd0);
  assign has_neg = neg_q;
  assign value   = $signed(neg_q ? 8'd0 - acc_q : acc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      if (neg) neg_q <= 1'b1;
      if (stb && dig && cnt_q != 2'd2) begin
        acc_q <= acc_q * 8'd10 + (ch - CH_0);
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cfg_cmd_parser.sv
// cfg_cmd_parser: collects a UART text line, parses "x=D" or
// "range=S,S", commits config or reports an error byte.
module cfg_cmd_parser
  import cfg_cmd_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int NUM_MAX   = 5,
  parameter int VAL_LO    = -3,
  parameter int VAL_HI    = 20,
  parameter int DEF_NUM   = 2,
  parameter int DEF_MIN   = 0,
  parameter int DEF_MAX   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic [3:0] max_mat_num,
  output logic [7:0] val_min,
  output logic [7:0] val_max,
  output logic       cfg_update,
  output logic       err_valid,
  output logic [2:0] err_code,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_ready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] FULL = PW'(BUF_DEPTH);
  localparam logic signed [7:0] NUM8 = 8'(NUM_MAX);
  localparam logic signed [7:0] LO8  = 8'(VAL_LO);
  localparam logic signed [7:0] HI8  = 8'(VAL_HI);

  logic [2:0]        state_q;
  logic [7:0]        mem_q [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              ovf_q;
  logic              is_x_q;
  logic [2:0]        kpos_q;
  logic [2:0]        res_err_q;
  logic signed [7:0] a_q;

  logic [7:0]        ch;
  logic              last;
  logic              key_ok;
  logic              in_field;
  logic              field_b;
  logic              minus_ok;
  logic              comma_ok;
  logic              acc_clr;
  logic              acc_stb;
  logic              acc_neg;
  logic              acc_empty;
  logic              acc_has_neg;
  logic              acc_ovl;
  logic              acc_nondig;
  logic signed [7:0] acc_val;

  assign busy     = (state_q != ST_COLLECT);
  assign ch       = to_lower(mem_q[rd_ptr[AW-1:0]]);
  assign last     = (rd_ptr == wr_ptr - PW'(1));
  assign in_field = (state_q == ST_SCAN_A) ||
                    (state_q == ST_SCAN_B);
  assign field_b  = (state_q == ST_SCAN_B);
  assign key_ok   = (kpos_q == 3'd0) ?
                    (ch == CH_X || ch == CH_R) :
                    (ch == key_char(is_x_q, kpos_q));
  assign minus_ok = !is_x_q && acc_empty && !acc_has_neg;
  assign comma_ok = !is_x_q && !field_b && !acc_empty;

  always_comb begin
    acc_clr = 1'b0;
    acc_stb = 1'b0;
    acc_neg = 1'b0;
    if (in_field) begin
      unique case (1'b1)
        (ch == CH_MINUS): acc_neg = 1'b1;
        (ch == CH_COMMA): acc_clr = 1'b1;
        default:          acc_stb = 1'b1;
      endcase
    end else if (state_q == ST_SCAN_KEY) begin
      acc_clr = 1'b1;
    end
  end

  dec_field_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .stb     (acc_stb),
    .neg     (acc_neg),
    .ch      (ch),
    .value   (acc_val),
    .empty   (acc_empty),
    .has_neg (acc_has_neg),
    .ovl     (acc_ovl),
    .nondig  (acc_nondig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf_q       <= 1'b0;
      is_x_q      <= 1'b0;
      kpos_q      <= '0;
      res_err_q   <= ERR_OK;
      a_q         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        mem_q[i] <= '0;
      max_mat_num <= 4'(DEF_NUM);
      val_min     <= 8'(DEF_MIN);
      val_max     <= 8'(DEF_MAX);
      cfg_update  <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_OK;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
    end else begin
      cfg_update <= 1'b0;
      err_valid  <= 1'b0;
      if (resp_valid && resp_ready)
        resp_valid <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          rd_ptr <= '0;
          kpos_q <= '0;
          if (rx_valid) begin
            if (rx_data == CH_CR || rx_data == CH_LF) begin
              if (wr_ptr != '0)
                state_q <= ST_SCAN_KEY;
            end else if (rx_data != CH_SP) begin
              if (wr_ptr == FULL) begin
                ovf_q <= 1'b1;
              end else begin
                mem_q[wr_ptr[AW-1:0]] <= rx_data;
                wr_ptr <= wr_ptr + PW'(1);
              end
            end
          end
        end
        // A keyword char on the last position leaves no field.
        ST_SCAN_KEY: begin
          rd_ptr <= rd_ptr + PW'(1);
          if (ovf_q || !key_ok || last) begin
            res_err_q <= ERR_FMT;
            state_q   <= ST_RESULT;
          end else begin
            if (kpos_q == 3'd0)
              is_x_q <= (ch == CH_X);
            if (kpos_q != 3'd0 && ch == CH_EQ)
              state_q <= ST_SCAN_A;
            kpos_q <= kpos_q + 3'd1;
          end
        end
        ST_SCAN_A, ST_SCAN_B: begin
          rd_ptr <= rd_ptr + PW'(1);
          if (ch == CH_MINUS) begin
            if (!minus_ok || last) begin
              res_err_q <= ERR_FMT;
              state_q   <= ST_RESULT;
            end
          end else if (ch == CH_COMMA) begin
            if (!comma_ok || last) begin
              res_err_q <= ERR_FMT;
              state_q   <= ST_RESULT;
            end else begin
              a_q     <= acc_val;
              state_q <= ST_SCAN_B;
            end
          end else if (acc_nondig || acc_ovl) begin
            res_err_q <= ERR_FMT;
            state_q   <= ST_RESULT;
          end else if (last) begin
            if (is_x_q || field_b) begin
              state_q <= ST_CHECK;
            end else begin
              res_err_q <= ERR_FMT;
              state_q   <= ST_RESULT;
            end
          end
        end
        ST_CHECK: begin
          state_q   <= ST_RESULT;
          res_err_q <= ERR_OK;
          if (is_x_q) begin
            if (acc_val == 8'sd0 || acc_val > NUM8)
              res_err_q <= ERR_CNT;
          end else if (a_q < LO8 || acc_val > HI8 ||
                       a_q > acc_val) begin
            res_err_q <= ERR_RNG;
          end
        end
        // Accumulator still holds D or B here.
        ST_RESULT: begin
          state_q    <= ST_COLLECT;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          kpos_q     <= '0;
          ovf_q      <= 1'b0;
          for (int i = 0; i < BUF_DEPTH; i++)
            mem_q[i] <= '0;
          resp_valid <= 1'b1;
          err_code   <= res_err_q;
          if (res_err_q == ERR_OK) begin
            cfg_update <= 1'b1;
            resp_data  <= CH_K;
            if (is_x_q) begin
              max_mat_num <= acc_val[3:0];
            end else begin
              val_min <= a_q;
              val_max <= acc_val;
            end
          end else begin
            err_valid <= 1'b1;
            resp_data <= CH_0 + {5'd0, res_err_q};
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule
